// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath widths and ALU operation encodings
// used by the ID/EX stage and its forwarding muxes.
package pipe_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // A bubble executes a harmless AND whose result is never written back.
    localparam logic [3:0] BUBBLE_ALU_CTRL = ALU_AND;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding select: picks the youngest in-flight producer of a
// register, falling back to the value captured from the register file.
module fwd_mux
    import pipe_pkg::*;
#(
    parameter int XLEN   = pipe_pkg::XLEN,
    parameter int REG_AW = pipe_pkg::REG_AW
) (
    input  logic [REG_AW-1:0] addr,
    input  logic [XLEN-1:0]   stored_data,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd_addr,
    input  logic [XLEN-1:0]   exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd_addr,
    input  logic [XLEN-1:0]   memwb_result,
    output logic [XLEN-1:0]   data
);

    always_comb begin
        // NOTE: default first so every path assigns data; no latch is inferred.
        data = stored_data;
        if (addr != '0) begin
            // EX/MEM is younger than MEM/WB, so it wins when both match.
            if (exmem_reg_write && (exmem_rd_addr == addr)) begin
                data = exmem_result;
            end else if (memwb_reg_write && (memwb_rd_addr == addr)) begin
                data = memwb_result;
            end
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU, with EX/MEM and MEM/WB result
// forwarding, stall (hold) and flush (bubble) control from the hazard unit.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int XLEN   = pipe_pkg::XLEN,
    parameter int REG_AW = pipe_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic              id_alu_src,
    input  logic [3:0]        id_alu_control,
    input  logic              id_reg_write,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd_addr,
    input  logic [XLEN-1:0]   exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd_addr,
    input  logic [XLEN-1:0]   memwb_result,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_src1,
    output logic [XLEN-1:0]   ex_src2,
    output logic [3:0]        ex_alu_control,
    output logic [XLEN-1:0]   ex_store_data,
    output logic [REG_AW-1:0] ex_rd_addr,
    output logic              ex_reg_write
);

    logic              valid_q;
    logic [REG_AW-1:0] rs1_addr_q;
    logic [REG_AW-1:0] rs2_addr_q;
    logic [REG_AW-1:0] rd_addr_q;
    logic [XLEN-1:0]   rs1_data_q;
    logic [XLEN-1:0]   rs2_data_q;
    logic [XLEN-1:0]   imm_q;
    logic              alu_src_q;
    logic [3:0]        alu_control_q;
    logic              reg_write_q;

    logic [XLEN-1:0]   rs1_fwd;
    logic [XLEN-1:0]   rs2_fwd;

    fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
        .addr            (rs1_addr_q),
        .stored_data     (rs1_data_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd_addr   (exmem_rd_addr),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd_addr   (memwb_rd_addr),
        .memwb_result    (memwb_result),
        .data            (rs1_fwd)
    );

    fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
        .addr            (rs2_addr_q),
        .stored_data     (rs2_data_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd_addr   (exmem_rd_addr),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd_addr   (memwb_rd_addr),
        .memwb_result    (memwb_result),
        .data            (rs2_fwd)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            // Reset and flush both leave a zeroed bubble; rd 0 can never be
            // forwarded, so the cleared data fields stay invisible downstream.
            valid_q       <= 1'b0;
            rs1_addr_q    <= '0;
            rs2_addr_q    <= '0;
            rd_addr_q     <= '0;
            rs1_data_q    <= '0;
            rs2_data_q    <= '0;
            imm_q         <= '0;
            alu_src_q     <= 1'b0;
            alu_control_q <= BUBBLE_ALU_CTRL;
            reg_write_q   <= 1'b0;
        end else if (stall) begin
            // Latch the forwarded operands so a producer retiring from MEM/WB
            // mid-stall does not take the value with it.
            rs1_data_q <= rs1_fwd;
            rs2_data_q <= rs2_fwd;
        end else begin
            valid_q       <= id_valid;
            rs1_addr_q    <= id_rs1_addr;
            rs2_addr_q    <= id_rs2_addr;
            rd_addr_q     <= id_rd_addr;
            rs1_data_q    <= id_rs1_data;
            rs2_data_q    <= id_rs2_data;
            imm_q         <= id_imm;
            alu_src_q     <= id_alu_src;
            alu_control_q <= id_alu_control;
            reg_write_q   <= id_reg_write;
        end
    end

    assign ex_valid       = valid_q;
    assign ex_src1        = rs1_fwd;
    assign ex_src2        = alu_src_q ? imm_q : rs2_fwd;
    assign ex_store_data  = rs2_fwd;
    assign ex_alu_control = alu_control_q;
    assign ex_rd_addr     = rd_addr_q;
    assign ex_reg_write   = reg_write_q & valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: expected outputs are queued when
// stimulus is applied and compared when the stage presents its result.
module tb_id_ex_stage;
    import pipe_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              stall;
    logic              flush;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1_addr;
    logic [REG_AW-1:0] id_rs2_addr;
    logic [REG_AW-1:0] id_rd_addr;
    logic [XLEN-1:0]   id_rs1_data;
    logic [XLEN-1:0]   id_rs2_data;
    logic [XLEN-1:0]   id_imm;
    logic              id_alu_src;
    logic [3:0]        id_alu_control;
    logic              id_reg_write;
    logic              exmem_reg_write;
    logic [REG_AW-1:0] exmem_rd_addr;
    logic [XLEN-1:0]   exmem_result;
    logic              memwb_reg_write;
    logic [REG_AW-1:0] memwb_rd_addr;
    logic [XLEN-1:0]   memwb_result;
    logic              ex_valid;
    logic [XLEN-1:0]   ex_src1;
    logic [XLEN-1:0]   ex_src2;
    logic [3:0]        ex_alu_control;
    logic [XLEN-1:0]   ex_store_data;
    logic [REG_AW-1:0] ex_rd_addr;
    logic              ex_reg_write;

    typedef struct {
        logic              valid;
        logic [XLEN-1:0]   src1;
        logic [XLEN-1:0]   src2;
        logic [3:0]        ctrl;
        logic [XLEN-1:0]   store;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    id_ex_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .flush           (flush),
        .id_valid        (id_valid),
        .id_rs1_addr     (id_rs1_addr),
        .id_rs2_addr     (id_rs2_addr),
        .id_rd_addr      (id_rd_addr),
        .id_rs1_data     (id_rs1_data),
        .id_rs2_data     (id_rs2_data),
        .id_imm          (id_imm),
        .id_alu_src      (id_alu_src),
        .id_alu_control  (id_alu_control),
        .id_reg_write    (id_reg_write),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd_addr   (exmem_rd_addr),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd_addr   (memwb_rd_addr),
        .memwb_result    (memwb_result),
        .ex_valid        (ex_valid),
        .ex_src1         (ex_src1),
        .ex_src2         (ex_src2),
        .ex_alu_control  (ex_alu_control),
        .ex_store_data   (ex_store_data),
        .ex_rd_addr      (ex_rd_addr),
        .ex_reg_write    (ex_reg_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic v, input logic [XLEN-1:0] s1, input logic [XLEN-1:0] s2,
                            input logic [3:0] c, input logic [XLEN-1:0] st,
                            input logic [REG_AW-1:0] rd, input logic rw);
        exp_t e;
        e.valid = v; e.src1 = s1; e.src2 = s2; e.ctrl = c;
        e.store = st; e.rd = rd; e.reg_write = rw;
        sb_q.push_back(e);
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        check({tag, ".sb_depth"}, sb_q.size(), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, ".valid"},     ex_valid,       e.valid);
            check({tag, ".src1"},      ex_src1,        e.src1);
            check({tag, ".src2"},      ex_src2,        e.src2);
            check({tag, ".ctrl"},      ex_alu_control, e.ctrl);
            check({tag, ".store"},     ex_store_data,  e.store);
            check({tag, ".rd"},        ex_rd_addr,     e.rd);
            check({tag, ".reg_write"}, ex_reg_write,   e.reg_write);
        end
        sb_q.delete();
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [REG_AW-1:0] a1, input logic [XLEN-1:0] d1,
                            input logic [REG_AW-1:0] a2, input logic [XLEN-1:0] d2,
                            input logic [XLEN-1:0] imm, input logic src, input logic [3:0] c,
                            input logic [REG_AW-1:0] rd, input logic rw);
        id_valid = v; id_rs1_addr = a1; id_rs1_data = d1; id_rs2_addr = a2; id_rs2_data = d2;
        id_imm = imm; id_alu_src = src; id_alu_control = c; id_rd_addr = rd; id_reg_write = rw;
    endtask

    task automatic drive_prod(input logic ew, input logic [REG_AW-1:0] erd, input logic [XLEN-1:0] eres,
                              input logic mw, input logic [REG_AW-1:0] mrd, input logic [XLEN-1:0] mres);
        exmem_reg_write = ew; exmem_rd_addr = erd; exmem_result = eres;
        memwb_reg_write = mw; memwb_rd_addr = mrd; memwb_result = mres;
    endtask

    initial begin
        logic [3:0] ops [6];
        ops = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR};
        stall = 1'b0;
        flush = 1'b0;

        // Reset with a valid, randomised instruction and live producers.
        rst_n = 1'b0;
        drive_id(1'b1, 5'($urandom_range(1, 31)), $urandom, 5'($urandom_range(1, 31)), $urandom,
                 $urandom, 1'b0, ALU_ADD, 5'($urandom_range(1, 31)), 1'b1);
        drive_prod(1'b1, 5'($urandom), $urandom, 1'b1, 5'($urandom), $urandom);
        for (int i = 0; i < 2; i++) begin
            push_exp(1'b0, '0, '0, ALU_AND, '0, '0, 1'b0);
            tick();
            compare_out($sformatf("reset%0d", i));
        end
        rst_n = 1'b1;

        // Plain load, no forwarding.
        drive_prod(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        drive_id(1'b1, 5'd1, 32'd5, 5'd2, 32'd7, 32'h0, 1'b0, ALU_ADD, 5'd3, 1'b1);
        push_exp(1'b1, 32'd5, 32'd7, ALU_ADD, 32'd7, 5'd3, 1'b1);
        tick();
        compare_out("plain_load");

        // Random loads with producers idle; first one is an invalid slot that must not write.
        for (int i = 0; i < 6; i++) begin
            logic              v, src, rw;
            logic [REG_AW-1:0] a1, a2, rd;
            logic [XLEN-1:0]   d1, d2, imm;
            logic [3:0]        c;
            v   = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            rw  = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            src = 1'($urandom_range(0, 1));
            a1 = 5'($urandom); a2 = 5'($urandom); rd = 5'($urandom);
            d1 = $urandom; d2 = $urandom; imm = $urandom;
            c  = ops[$urandom_range(0, 5)];
            drive_prod(1'b0, 5'($urandom), $urandom, 1'b0, 5'($urandom), $urandom);
            drive_id(v, a1, d1, a2, d2, imm, src, c, rd, rw);
            push_exp(v, d1, src ? imm : d2, c, d2, rd, rw & v);
            tick();
            compare_out($sformatf("rand_load%0d", i));
        end

        // Forwarding priority on a stalled rs1=x4 / rs2=x5 instruction.
        drive_prod(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        drive_id(1'b1, 5'd4, 32'd1, 5'd5, 32'd2, 32'h0, 1'b0, ALU_OR, 5'd7, 1'b1);
        push_exp(1'b1, 32'd1, 32'd2, ALU_OR, 32'd2, 5'd7, 1'b1);
        tick();
        compare_out("fwd_base");
        stall = 1'b1;
        drive_prod(1'b1, 5'd4, 32'hAA, 1'b1, 5'd4, 32'hBB);
        push_exp(1'b1, 32'hAA, 32'd2, ALU_OR, 32'd2, 5'd7, 1'b1);
        #1;
        compare_out("fwd_exmem_prio");
        exmem_reg_write = 1'b0;
        push_exp(1'b1, 32'hBB, 32'd2, ALU_OR, 32'd2, 5'd7, 1'b1);
        #1;
        compare_out("fwd_memwb");
        drive_prod(1'b1, 5'd5, 32'hCC, 1'b1, 5'd4, 32'hBB);
        push_exp(1'b1, 32'hBB, 32'hCC, ALU_OR, 32'hCC, 5'd7, 1'b1);
        #1;
        compare_out("fwd_independent");
        stall = 1'b0;

        // x0 operands never forward, even with both producers targeting x0.
        drive_prod(1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB);
        drive_id(1'b1, 5'd0, 32'h11, 5'd0, 32'h22, 32'h0, 1'b0, ALU_ADD, 5'd8, 1'b1);
        push_exp(1'b1, 32'h11, 32'h22, ALU_ADD, 32'h22, 5'd8, 1'b1);
        tick();
        compare_out("fwd_x0");

        // Immediate select: src2 takes imm, store data still gets forwarded rs2.
        drive_prod(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'h55);
        drive_id(1'b1, 5'd3, 32'h3, 5'd8, 32'h99, 32'hFFFF_FFF0, 1'b1, ALU_ADD, 5'd10, 1'b1);
        push_exp(1'b1, 32'h3, 32'hFFFF_FFF0, ALU_ADD, 32'h55, 5'd10, 1'b1);
        tick();
        compare_out("imm_select");

        // Stall across retirement of the MEM/WB producer of rs2=x6.
        drive_prod(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h1234);
        drive_id(1'b1, 5'd1, 32'h10, 5'd6, 32'h0, 32'h0, 1'b0, ALU_SUB, 5'd12, 1'b1);
        push_exp(1'b1, 32'h10, 32'h1234, ALU_SUB, 32'h1234, 5'd12, 1'b1);
        tick();
        compare_out("stall_load");
        stall = 1'b1;
        drive_id(1'b0, 5'd2, 32'hBAD0, 5'd3, 32'hBAD1, 32'hBAD2, 1'b1, ALU_NOR, 5'd20, 1'b0);
        for (int i = 0; i < 3; i++) begin
            push_exp(1'b1, 32'h10, 32'h1234, ALU_SUB, 32'h1234, 5'd12, 1'b1);
            tick();
            drive_prod(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'hDEAD);
            compare_out($sformatf("stall_hold%0d", i));
        end

        // Flush wins over stall on the same edge.
        flush = 1'b1;
        push_exp(1'b0, '0, '0, ALU_AND, '0, '0, 1'b0);
        tick();
        compare_out("flush_over_stall");
        flush = 1'b0;
        stall = 1'b0;

        // Stage recovers and loads normally after the bubble.
        drive_prod(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        drive_id(1'b1, 5'd7, 32'h77, 5'd9, 32'h99, 32'h0, 1'b0, ALU_SLT, 5'd15, 1'b1);
        push_exp(1'b1, 32'h77, 32'h99, ALU_SLT, 32'h99, 5'd15, 1'b1);
        tick();
        compare_out("post_flush_load");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register directly upstream of the ALU.
- Captures decoded operands and control each cycle and applies EX/MEM and MEM/WB result forwarding.
- Drives the ALU src1, src2 and alu_control inputs, plus pass-through destination and control to EX/MEM.
- Supports stall (hold) and flush (bubble insertion) from the hazard unit.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- stall  in  1  hold stage contents.
- flush  in  1  replace stage contents with a bubble.
- id_valid  in  1  decode slot holds a real instruction.
- id_rs1_addr  in  REG_AW  source 1 register index.
- id_rs2_addr  in  REG_AW  source 2 register index.
- id_rd_addr  in  REG_AW  destination register index.
- id_rs1_data  in  XLEN  register file read data 1.
- id_rs2_data  in  XLEN  register file read data 2.
- id_imm  in  XLEN  sign-extended immediate.
- id_alu_src  in  1  1 = src2 is the immediate, 0 = src2 is rs2.
- id_alu_control  in  4  ALU op code (0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR).
- id_reg_write  in  1  instruction writes rd.
- exmem_reg_write  in  1  EX/MEM producer writes.
- exmem_rd_addr  in  REG_AW  EX/MEM destination.
- exmem_result  in  XLEN  EX/MEM result.
- memwb_reg_write  in  1  MEM/WB producer writes.
- memwb_rd_addr  in  REG_AW  MEM/WB destination.
- memwb_result  in  XLEN  MEM/WB writeback value.
- ex_valid  out  1  stage holds a real instruction.
- ex_src1  out  XLEN  ALU src1 (forwarded).
- ex_src2  out  XLEN  ALU src2 (immediate or forwarded rs2).
- ex_alu_control  out  4  ALU op code.
- ex_store_data  out  XLEN  forwarded rs2, for stores.
- ex_rd_addr  out  REG_AW  destination, to EX/MEM.
- ex_reg_write  out  1  qualified write enable (reg_write AND valid).

Behaviour:
- Registered fields: valid, rs1/rs2 addr, rd addr, rs1/rs2 data, imm, alu_src, alu_control, reg_write. All update only on the rising edge of clk.
- Reset: rst_n low at an edge clears every register to 0. Resulting outputs: ex_valid 0, ex_alu_control 0000, ex_rd_addr 0, ex_reg_write 0, ex_src1/ex_src2/ex_store_data 0 (no forward can match rd 0).
- Priority per edge: reset > flush > stall > load.
  - Load: capture all id_* fields.
  - Flush: valid = 0, reg_write = 0, alu_control = 0000, rd = 0; data fields are don't-care but are cleared to 0.
  - Stall without flush: address and control fields hold. The rs1/rs2 data registers are rewritten with their current forwarded values. The operand is therefore preserved if the producer retires from MEM/WB during a multi-cycle stall.
- Forwarding is combinational on registered operands and is evaluated independently for rs1 and rs2. For operand index a:
  - If a == 0: use the stored data, never forward.
  - Else if exmem_reg_write and exmem_rd_addr == a: use exmem_result.
  - Else if memwb_reg_write and memwb_rd_addr == a: use memwb_result.
  - Else: use the stored data.
  - EX/MEM has priority over MEM/WB when both match.
- ex_src1 = fwd(rs1).
- ex_src2 = alu_src ? imm : fwd(rs2).
- ex_store_data = fwd(rs2), independent of alu_src.
- Latency: id_* to ex_* is one cycle. Forward inputs to ex_src* is zero cycles (combinational).
- ex_reg_write = registered reg_write AND registered valid. An id_valid=0 slot therefore never writes.
- Decode-stage write-through of a same-cycle writeback belongs to the register file, not this block.
- Widths: all data paths are XLEN with no extension or truncation. The immediate arrives pre-extended.

Decomposition:
- Shared package pipe_pkg: XLEN, REG_AW, ALU op code constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR), BUBBLE_ALU_CTRL = ALU_AND.
- One sub-module, fwd_mux: inputs are operand addr, stored data and both producer tuples; output is the selected value. Instantiated twice (rs1, rs2).

Test Plan:
- Reset: rst_n=0 for 2 cycles with id_valid=1 and random inputs -> ex_valid=0, ex_reg_write=0, ex_alu_control=0000, ex_src1=ex_src2=0.
- Plain load: rs1_data=5, rs2_data=7, alu_src=0, alu_control=0010, rd=3, no forward matches -> next cycle ex_src1=5, ex_src2=7, ex_alu_control=0010, ex_rd_addr=3, ex_reg_write=1.
- Forward priority: stored rs1 = x4 with data 1; exmem (rd=4, wr=1, result=0xAA) and memwb (rd=4, wr=1, result=0xBB) -> ex_src1=0xAA. Drop exmem_reg_write -> ex_src1=0xBB. Set rs1 addr = x0 with both producers targeting 0 -> stored data is used.
- Immediate select: alu_src=1, imm=0xFFFFFFF0, rs2 forwarded 0x55 -> ex_src2=0xFFFFFFF0, ex_store_data=0x55.
- Stall across retirement: rs2 = x6 forwarded from memwb (0x1234). Hold stall 3 cycles while memwb moves to rd=9 -> ex_src2 stays 0x1234 and ex_valid is held.
- Flush vs stall: flush=1 and stall=1 on the same edge with a valid instruction present -> ex_valid=0, ex_reg_write=0, ex_alu_control=0000, ex_rd_addr=0.
